// File: rtl/lane_collision_detect.sv
// Per-lane frog/car collision detector: debounces pixel overlap at the frog's position
// over CONFIRM consecutive cycles and latches a sticky hit until reset.
module lane_collision_detect #(
  parameter logic [3:0]  LANE_ROW = 4'd10,
  parameter int unsigned CONFIRM  = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic [15:0] lane_pixels,
  input  logic [3:0]  frog_row,
  input  logic [3:0]  frog_col,
  input  logic        frog_valid,
  output logic        hit,
  output logic        hit_pulse,
  output logic        frog_on_lane
);

  localparam logic [3:0] ConfirmVal = 4'(CONFIRM);

  typedef enum logic [1:0] {StClear, StConfirm, StHit} state_e;

  state_e     state_q;
  logic [3:0] cnt_q;
  logic       overlap;

  assign overlap = enable & frog_valid & (frog_row == LANE_ROW) & lane_pixels[frog_col];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= StClear;
      cnt_q        <= 4'd0;
      hit          <= 1'b0;
      hit_pulse    <= 1'b0;
      frog_on_lane <= 1'b0;
    end else begin
      frog_on_lane <= frog_valid & (frog_row == LANE_ROW);
      hit_pulse    <= 1'b0;
      case (state_q)
        StClear: begin
          if (overlap) begin
            if (ConfirmVal == 4'd1) begin
              state_q   <= StHit;
              hit       <= 1'b1;
              hit_pulse <= 1'b1;
            end else begin
              state_q <= StConfirm;
              cnt_q   <= 4'd1;
            end
          end else begin
            cnt_q <= 4'd0;
          end
        end
        StConfirm: begin
          // Any gap in overlap restarts the debounce from scratch.
          if (!overlap) begin
            state_q <= StClear;
            cnt_q   <= 4'd0;
          end else if (cnt_q + 4'd1 == ConfirmVal) begin
            state_q   <= StHit;
            hit       <= 1'b1;
            hit_pulse <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 4'd1;
          end
        end
        StHit: begin
          state_q <= StHit;
        end
        default: begin
          state_q <= StClear;
          cnt_q   <= 4'd0;
        end
      endcase
    end
  end

endmodule
